// File: rtl/serial_adder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_pkg
// Shared definitions for the bit-serial adder controller: the default operand
// width and the FSM state encodings.
// -----------------------------------------------------------------------------
package serial_adder_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_if
// Request/result bundle between a requester and the serial adder controller.
//   start      : request, sampled by the controller in IDLE or DONE
//   a, b, cin  : operands, captured when start is accepted
//   busy       : high while the controller is shifting bits
//   done       : one-cycle pulse, sum/cout valid
//   sum, cout  : result, held until the next accepted start
// master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
interface serial_adder_ctrl_if
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/serial_adder_ctrl_full_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell
// Purely combinational one-bit full adder, time-shared by serial_adder_ctrl.
//   a_i, b_i, cin_i : addend bits and carry-in
//   sum_o, cout_o   : sum bit and carry-out
// -----------------------------------------------------------------------------
module full_adder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in one bit per
// clock, LSB first, through a single full_adder_cell. Result {cout, sum}
// appears WIDTH+1 cycles after start is accepted, marked by a done pulse.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request/result bundle (slave side)
// -----------------------------------------------------------------------------
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_ctrl_if.slave   bus
);

    localparam int unsigned       CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q,  carry_d;

    logic cell_sum;
    logic cell_cout;

    full_adder_cell u_cell (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .cin_i  (carry_q),
        .sum_o  (cell_sum),
        .cout_o (cell_cout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    // sum_sh is left alone so the previous result stays
                    // visible until the new bits start shifting in.
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                // Sum bits enter at the MSB end; after WIDTH shifts bit 0
                // of the result has reached sum_sh[0].
                sum_sh_d = {cell_sum, sum_sh_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = cell_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.sum  = sum_sh_q;
    assign bus.cout = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Self-checking bench for serial_adder_ctrl with WIDTH=8.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the DONE cycle.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         output logic [W-1:0] s, output logic co,
                         output int lat, output int busy_n);
        bus.a = a; bus.b = b; bus.cin = cin; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = ~a; bus.b = ~b; bus.cin = ~cin;
        lat = 0; busy_n = 0; s = '0; co = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_n++;
            check("busy_done_overlap", {31'd0, bus.busy & bus.done}, 32'd0);
            if (bus.done) begin
                s  = bus.sum;
                co = bus.cout;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    vec_t vecs[10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] s;
        logic         co;
        int           lat, busy_n, dones, done_at, last_done, busy_seen;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   exp9;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
        vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[5] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[7] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
        vecs[8] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[9] = '{8'h01, 8'hFE, 1'b1, 8'h00, 1'b1};

        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;

        // Reset state
        #12;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_sum",  {24'd0, bus.sum},  32'd0);
        check("rst_cout", {31'd0, bus.cout}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, lat, busy_n);
            check("vec_sum",     {24'd0, s},  {24'd0, vecs[i].s});
            check("vec_cout",    {31'd0, co}, {31'd0, vecs[i].co});
            check("vec_latency", lat,    W + 1);
            check("vec_busy_n",  busy_n, W);
        end

        // start during RUN is ignored; inputs may change freely
        bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dones = 0; done_at = 0; s = '0; co = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++; done_at = k; s = bus.sum; co = bus.cout;
            end
            if (k == 3) begin
                bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
            end else if (k == 4) begin
                bus.start = 1'b0; bus.a = 8'hC3; bus.b = 8'h96;
            end
        end
        check("ign_dones",   dones,   1);
        check("ign_done_at", done_at, W + 1);
        check("ign_sum",     {24'd0, s},  32'h46);
        check("ign_cout",    {31'd0, co}, 32'd0);
        check("ign_idle",    {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset mid-RUN after 4 bits
        bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_done", {31'd0, bus.done}, 32'd0);
        check("arst_sum",  {24'd0, bus.sum},  32'd0);
        check("arst_cout", {31'd0, bus.cout}, 32'd0);
        #1 rst_n = 1'b1;
        dones = 0; busy_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (bus.busy) busy_seen++;
        end
        check("arst_no_done", dones,     0);
        check("arst_no_busy", busy_seen, 0);
        @(posedge clk); #1;
        do_op(8'h01, 8'h01, 1'b0, s, co, lat, busy_n);
        check("post_rst_sum",  {24'd0, s},  32'h02);
        check("post_rst_cout", {31'd0, co}, 32'd0);
        check("post_rst_lat",  lat, W + 1);

        // Back-to-back with start held high
        bus.a = 8'h80; bus.b = 8'h80; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        dones = 0; last_done = 0;
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk);
            check("b2b_no_gap", {31'd0, bus.busy | bus.done}, 32'd1);
            if (bus.done) begin
                dones++;
                check("b2b_spacing", k - last_done, W + 1);
                check("b2b_sum",  {24'd0, bus.sum},  32'd0);
                check("b2b_cout", {31'd0, bus.cout}, 32'd1);
                last_done = k;
            end
            if (k == 27) bus.start = 1'b0;
        end
        check("b2b_dones", dones, 3);
        @(posedge clk); #1;
        check("b2b_idle", {30'd0, bus.busy, bus.done}, 32'd0);

        // Random operations with random gaps
        for (int i = 0; i < 500; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            do_op(ra, rb, rc, s, co, lat, busy_n);
            exp9 = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            check("rnd_result",  {23'd0, co, s}, {23'd0, exp9});
            check("rnd_latency", lat, W + 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
